// File: rtl/sm_ibuf_pkg.sv
// Shared types and default sizing for the per-warp instruction buffer.
// An entry is stored as {pc, inst}; the PC occupies the upper bits.
package sm_ibuf_pkg;

  localparam int DEF_NUM_WARPS = 4;
  localparam int DEF_DEPTH     = 2;
  localparam int DEF_INST_W    = 32;
  localparam int DEF_PC_W      = 32;

  typedef struct packed {
    logic [DEF_PC_W-1:0]   pc;
    logic [DEF_INST_W-1:0] inst;
  } ibuf_entry_t;

endpackage

// File: rtl/ibuf_fifo.sv
// Single-warp circular FIFO with extra-wrap-bit pointers and a synchronous clear.
// Clear (branch flush) takes priority over any push or pop in the same cycle.
module ibuf_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && !clear && push && !full)
      mem[wr_ptr[AW-1:0]] <= din;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/warp_ibuffer.sv
// Per-warp instruction buffer feeding the round-robin arbiter and the issue stage.
// Decodes write/pop/flush targets onto one ibuf_fifo per warp and muxes the granted head.
module warp_ibuffer
  import sm_ibuf_pkg::*;
#(
  parameter int   NUM_WARPS = DEF_NUM_WARPS,
  parameter int   DEPTH     = DEF_DEPTH,
  parameter int   INST_W    = DEF_INST_W,
  parameter int   PC_W      = DEF_PC_W,
  localparam int  WID_W     = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WID_W-1:0]     in_warp,
  input  logic [INST_W-1:0]    in_inst,
  input  logic [PC_W-1:0]      in_pc,
  input  logic [NUM_WARPS-1:0] stall,
  output logic [NUM_WARPS-1:0] req,
  input  logic [WID_W-1:0]     grant,
  input  logic                 grant_valid,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WID_W-1:0]     out_warp,
  output logic [INST_W-1:0]    out_inst,
  output logic [PC_W-1:0]      out_pc,
  input  logic                 flush,
  input  logic [WID_W-1:0]     flush_warp,
  output logic [NUM_WARPS-1:0] full
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  logic [NUM_WARPS-1:0] empty;
  logic [NUM_WARPS-1:0] push;
  logic [NUM_WARPS-1:0] pop;
  logic [NUM_WARPS-1:0] clear;
  entry_t               head [NUM_WARPS];
  entry_t               wr_entry;
  entry_t               head_sel;
  logic                 flush_hits_grant;

  assign wr_entry = '{pc: in_pc, inst: in_inst};

  assign in_ready = !full[in_warp];
  assign req      = ~empty & ~stall;

  // A flush of the granted warp must also suppress the pop, since the entry is being discarded.
  assign flush_hits_grant = flush && (flush_warp == grant);
  assign out_valid = grant_valid && !empty[grant] && !stall[grant] && !flush_hits_grant;

  assign out_warp = grant;
  assign head_sel = head[grant];
  assign out_inst = head_sel.inst;
  assign out_pc   = head_sel.pc;

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    assign clear[w] = flush && (flush_warp == WID_W'(w));
    assign push[w]  = in_valid && in_ready && (in_warp == WID_W'(w)) && !clear[w];
    assign pop[w]   = out_valid && out_ready && (grant == WID_W'(w));

    ibuf_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[w]),
      .pop   (pop[w]),
      .clear (clear[w]),
      .din   (wr_entry),
      .head  (head[w]),
      .empty (empty[w]),
      .full  (full[w])
    );
  end

endmodule

// File: tb/tb_warp_ibuffer.sv
// Directed bench for warp_ibuffer with hand-computed expectations and a small
// round-robin arbiter model that can be switched in to drive grant/grant_valid.
module tb_warp_ibuffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_warp;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [3:0]  stall;
  logic [3:0]  req;
  logic [1:0]  grant;
  logic        grant_valid;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_warp;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        flush;
  logic [1:0]  flush_warp;
  logic [3:0]  full;

  logic [1:0]  grant_drv;
  logic        gv_drv;
  logic        arb_en;
  logic [1:0]  arb_grant;
  logic        arb_gv;
  logic [1:0]  arb_last;
  logic [1:0]  arb_pick;
  logic        arb_found;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign grant       = arb_en ? arb_grant : grant_drv;
  assign grant_valid = arb_en ? arb_gv    : gv_drv;

  warp_ibuffer dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_warp     (in_warp),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .stall       (stall),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_warp    (out_warp),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .flush       (flush),
    .flush_warp  (flush_warp),
    .full        (full)
  );

  // Round-robin arbiter with a registered grant, searching from the warp after the last winner.
  always_comb begin
    arb_pick  = arb_last;
    arb_found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (!arb_found && req[2'(int'(arb_last) + i)]) begin
        arb_pick  = 2'(int'(arb_last) + i);
        arb_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!arb_en) begin
      arb_gv    <= 1'b0;
      arb_grant <= 2'd0;
      arb_last  <= 2'd0;
    end else begin
      arb_gv <= |req;
      if (|req) begin
        arb_grant <= arb_pick;
        arb_last  <= arb_pick;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [1:0] w, input logic [31:0] pc);
    in_valid = 1'b1;
    in_warp  = w;
    in_pc    = pc;
    in_inst  = pc ^ 32'hA5A5_0000;
    step();
    in_valid = 1'b0;
  endtask

  int          n_out;
  logic [1:0]  exp_order [4];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_warp = 2'd0; in_inst = '0; in_pc = '0;
    stall = 4'b0; grant_drv = 2'd0; gv_drv = 1'b0; out_ready = 1'b0;
    flush = 1'b0; flush_warp = 2'd0; arb_en = 1'b0;
    step(); step();
    rst = 1'b0;
    gv_drv = 1'b1;
    #1;
    chk("rst_req", req, 4'b0000);
    chk("rst_full", full, 4'b0000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    gv_drv = 1'b0;

    // Single write to warp 2, then pop
    in_valid = 1'b1; in_warp = 2'd2; in_pc = 32'h100; in_inst = 32'hA;
    #1;
    chk("t1_no_bypass", req, 4'b0000);
    step();
    in_valid = 1'b0;
    #1;
    chk("t1_req", req, 4'b0100);
    grant_drv = 2'd2; gv_drv = 1'b1; out_ready = 1'b1;
    #1;
    chk("t1_out_valid", out_valid, 1'b1);
    chk("t1_out_pc", out_pc, 32'h100);
    chk("t1_out_inst", out_inst, 32'hA);
    chk("t1_out_warp", out_warp, 2'd2);
    step();
    chk("t1_req_after", req, 4'b0000);
    chk("t1_valid_after", out_valid, 1'b0);
    gv_drv = 1'b0;

    // Fill warp 1 and attempt a third write
    push_one(2'd1, 32'h200);
    push_one(2'd1, 32'h204);
    #1;
    chk("t2_full", full, 4'b0010);
    in_warp = 2'd1;
    #1;
    chk("t2_ready_w1", in_ready, 1'b0);
    in_warp = 2'd0;
    #1;
    chk("t2_ready_w0", in_ready, 1'b1);
    in_valid = 1'b1; in_warp = 2'd1; in_pc = 32'h208;
    step();
    in_valid = 1'b0;
    grant_drv = 2'd1; gv_drv = 1'b1; out_ready = 1'b1;
    #1;
    chk("t2_pop0", out_pc, 32'h200);
    step();
    chk("t2_pop1", out_pc, 32'h204);
    chk("t2_pop1_inst", out_inst, 32'h204 ^ 32'hA5A5_0000);
    step();
    chk("t2_drained", out_valid, 1'b0);
    chk("t2_req", req, 4'b0000);
    gv_drv = 1'b0;

    // One entry per warp with the arbiter attached
    for (int w = 0; w < 4; w++) push_one(2'(w), 32'h300 + w);
    exp_order[0] = 2'd1; exp_order[1] = 2'd2; exp_order[2] = 2'd3; exp_order[3] = 2'd0;
    n_out = 0;
    arb_en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (out_valid) begin
        if (n_out < 4) begin
          chk("t3_warp", out_warp, exp_order[n_out]);
          chk("t3_pc", out_pc, 32'h300 + exp_order[n_out]);
        end
        n_out++;
      end
    end
    chk("t3_count", n_out, 4);
    chk("t3_req", req, 4'b0000);
    arb_en = 1'b0;

    // Stall blocks request and issue of warp 3
    stall = 4'b1000;
    push_one(2'd3, 32'h400);
    push_one(2'd3, 32'h404);
    grant_drv = 2'd3; gv_drv = 1'b1; out_ready = 1'b1;
    #1;
    chk("t4_req_stalled", req, 4'b0000);
    chk("t4_valid_stalled", out_valid, 1'b0);
    step();
    stall = 4'b0000;
    #1;
    chk("t4_req_release", req, 4'b1000);
    chk("t4_pop0", out_pc, 32'h400);
    step();
    chk("t4_pop1", out_pc, 32'h404);
    step();
    chk("t4_drained", out_valid, 1'b0);
    gv_drv = 1'b0;

    // Flush warp 0 while writing to it and granting it
    push_one(2'd0, 32'h500);
    flush = 1'b1; flush_warp = 2'd0;
    in_valid = 1'b1; in_warp = 2'd0; in_pc = 32'h504;
    grant_drv = 2'd0; gv_drv = 1'b1; out_ready = 1'b1;
    #1;
    chk("t5_valid_flush", out_valid, 1'b0);
    chk("t5_in_ready", in_ready, 1'b1);
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("t5_req", req, 4'b0000);
    chk("t5_valid_after", out_valid, 1'b0);
    gv_drv = 1'b0;

    // Concurrent push and pop on warp 1 across pointer wraps
    push_one(2'd1, 32'h600);
    grant_drv = 2'd1; gv_drv = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_warp = 2'd1; in_pc = 32'h601 + i; in_inst = 32'h0;
      #1;
      chk("t6_valid", out_valid, 1'b1);
      chk("t6_pc", out_pc, 32'h600 + i);
      chk("t6_full", full[1], 1'b0);
      step();
    end
    in_valid = 1'b0;
    #1;
    chk("t6_last", out_pc, 32'h60A);
    step();
    chk("t6_empty", req, 4'b0000);
    gv_drv = 1'b0;

    // Reset mid-operation discards entries and a concurrent write
    push_one(2'd2, 32'h700);
    rst = 1'b1; in_valid = 1'b1; in_warp = 2'd1; in_pc = 32'h704;
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("t7_req", req, 4'b0000);
    chk("t7_full", full, 4'b0000);
    step();
    chk("t7_req_later", req, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
